// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width/limits, converter FSM states, digit validity check.
package bcd_pkg;

  localparam int          BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    ERRD  = 2'd3
  } state_t;

  function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// Reverse double-dabble digit correction: after a right shift, digits >= 8 subtract 3.
module bcd_digit_corr
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_d,
  output logic [BCD_W-1:0] o_d
);

  assign o_d = (i_d >= 4'd8) ? (i_d - 4'd3) : i_d;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one reverse double-dabble shift per clock.
// Start/Done handshake; invalid digits short-circuit to a one-cycle error Done.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 3,
  parameter int BW      = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [BCD_W*NDIGITS-1:0] i_bcd_in,
  output logic                     o_ready,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [BW-1:0]            o_bin_out,
  output logic                     o_err
);

  localparam int DW = BCD_W * NDIGITS;
  localparam int SW = DW + BW;
  localparam int CW = (BW > 1) ? $clog2(BW) : 1;

  state_t          r_state;
  state_t          w_next;
  logic [SW-1:0]   r_sreg;
  logic [CW-1:0]   r_cnt;
  logic [BW-1:0]   r_bin;
  logic            r_err;

  logic [SW-1:0]   w_shifted;
  logic [SW-1:0]   w_corr;
  logic            w_valid;
  logic            w_last;
  logic            w_accept;

  assign w_shifted = r_sreg >> 1;
  assign w_corr[BW-1:0] = w_shifted[BW-1:0];

  // Digit fields occupy the bits above the binary accumulator.
  for (genvar g = 0; g < NDIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .i_d (w_shifted[BW + BCD_W*g +: BCD_W]),
      .o_d (w_corr[BW + BCD_W*g +: BCD_W])
    );
  end

  always_comb begin
    w_valid = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (!bcd_valid(i_bcd_in[BCD_W*i +: BCD_W])) w_valid = 1'b0;
    end
  end

  assign w_last   = (r_cnt == CW'(BW - 1));
  assign w_accept = (r_state == IDLE) && i_start;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = w_valid ? SHIFT : ERRD;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      ERRD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept && w_valid) begin
        r_sreg <= {i_bcd_in, {BW{1'b0}}};
        r_cnt  <= '0;
      end else if (w_accept) begin
        r_bin <= '0;
        r_err <= 1'b1;
      end else if (r_state == SHIFT) begin
        r_sreg <= w_corr;
        r_cnt  <= r_cnt + CW'(1);
        if (w_last) begin
          r_bin <= w_corr[BW-1:0];
          r_err <= 1'b0;
        end
      end
    end
  end

  assign o_ready   = (r_state == IDLE);
  assign o_busy    = (r_state != IDLE);
  assign o_done    = (r_state == DONE) || (r_state == ERRD);
  assign o_bin_out = r_bin;
  assign o_err     = r_err;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: vector table, random vectors vs decimal model, corner sequences.
module tb_bcd_to_bin_seq;

  localparam int NDIGITS = 3;
  localparam int BW      = 10;
  localparam int LAT_OK  = BW + 1;
  localparam int LAT_ERR = 1;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [11:0]   i_bcd_in;
  logic          o_ready, o_busy, o_done, o_err;
  logic [BW-1:0] o_bin_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.NDIGITS(NDIGITS), .BW(BW)) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_bcd_in  (i_bcd_in),
    .o_ready   (o_ready),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_bin_out (o_bin_out),
    .o_err     (o_err)
  );

  typedef struct {
    logic [11:0] bcd;
    int          exp_bin;
    int          exp_err;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Decimal reading of the digits; any digit above 9 is an error with result 0.
  function automatic void model(input logic [11:0] b, output int v, output int e);
    int d;
    v = 0;
    e = 0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      d = int'((b >> (4 * i)) & 12'hF);
      if (d > 9) e = 1;
      v = v * 10 + d;
    end
    if (e != 0) v = 0;
  endfunction

  // Start one conversion and watch for Done; optional second Start pulse while busy.
  task automatic run_conv(input logic [11:0] bcd, input int repulse_k, input logic [11:0] rebcd,
                          input int exp_bin, input int exp_err, input int exp_lat, input string tag);
    int k;
    bit seen;
    @(negedge clk);
    chk({tag, " ready"}, {31'd0, o_ready}, 32'd1);
    i_start  = 1'b1;
    i_bcd_in = bcd;
    @(posedge clk);
    @(negedge clk);
    i_start  = 1'b0;
    i_bcd_in = 12'($urandom);
    k    = 1;
    seen = 1'b0;
    while (k <= 40 && !seen) begin
      if (o_done) begin
        seen = 1'b1;
      end else begin
        if (o_ready === o_busy) chk({tag, " ready/busy exclusive"}, {31'd0, o_busy}, {31'd0, ~o_ready});
        i_start  = (k == repulse_k);
        if (k == repulse_k) i_bcd_in = rebcd;
        @(negedge clk);
        k++;
      end
    end
    i_start = 1'b0;
    chk({tag, " latency"}, seen ? k : -1, exp_lat);
    chk({tag, " bin"}, {22'd0, o_bin_out}, exp_bin);
    chk({tag, " err"}, {31'd0, o_err}, exp_err);
    @(negedge clk);
    chk({tag, " done width"}, {30'd0, o_done, o_ready}, 32'd1);
  endtask

  vec_t tbl[10];

  initial begin
    int v, e, k, ndone;
    int dt[3];
    int db[3];
    logic [11:0] b;

    tbl[0] = '{12'h999, 999, 0, LAT_OK};
    tbl[1] = '{12'h000,   0, 0, LAT_OK};
    tbl[2] = '{12'h512, 512, 0, LAT_OK};
    tbl[3] = '{12'h9A5,   0, 1, LAT_ERR};
    tbl[4] = '{12'h001,   1, 0, LAT_OK};
    tbl[5] = '{12'h010,  10, 0, LAT_OK};
    tbl[6] = '{12'h100, 100, 0, LAT_OK};
    tbl[7] = '{12'hF00,   0, 1, LAT_ERR};
    tbl[8] = '{12'h998, 998, 0, LAT_OK};
    tbl[9] = '{12'h00B,   0, 1, LAT_ERR};

    i_rst    = 1'b1;
    i_start  = 1'b0;
    i_bcd_in = 12'h000;
    repeat (3) @(negedge clk);
    chk("reset flags", {28'd0, o_ready, o_busy, o_done, o_err}, 32'b1000);
    chk("reset bin", {22'd0, o_bin_out}, 32'd0);
    i_rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_conv(tbl[i].bcd, 0, 12'h000, tbl[i].exp_bin, tbl[i].exp_err, tbl[i].exp_lat,
               $sformatf("tbl%0d", i));

    // Second Start mid-conversion must be ignored.
    run_conv(12'h123, 4, 12'h456, 123, 0, LAT_OK, "repulse");

    // Reset after the fifth shift aborts without a Done.
    @(negedge clk);
    i_start  = 1'b1;
    i_bcd_in = 12'h789;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    repeat (5) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    chk("midreset flags", {28'd0, o_ready, o_busy, o_done, o_err}, 32'b1000);
    chk("midreset bin", {22'd0, o_bin_out}, 32'd0);
    i_rst = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (o_done) ndone++;
    end
    chk("midreset no done", ndone, 0);
    run_conv(12'h042, 0, 12'h000, 42, 0, LAT_OK, "after reset");

    // Start held high: back-to-back conversions every BW+2 cycles.
    @(negedge clk);
    i_start  = 1'b1;
    i_bcd_in = 12'h250;
    ndone = 0;
    k = 0;
    while (k < 60 && ndone < 3) begin
      @(negedge clk);
      k++;
      if (o_done) begin
        dt[ndone] = k;
        db[ndone] = int'(o_bin_out);
        ndone++;
      end
    end
    i_start = 1'b0;
    chk("held done count", ndone, 3);
    for (int i = 0; i < ndone; i++) chk($sformatf("held bin%0d", i), db[i], 250);
    for (int i = 1; i < ndone; i++) chk($sformatf("held gap%0d", i), dt[i] - dt[i-1], BW + 2);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      b = 12'h000;
      for (int d = 0; d < NDIGITS; d++) b[4*d +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) b[4*$urandom_range(0, NDIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      model(b, v, e);
      run_conv(b, 0, 12'h000, v, e, (e != 0) ? LAT_ERR : LAT_OK, $sformatf("rnd%0d %h", i, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
